// File: rtl/sh7604_ibus_master_pkg.sv
// Shared types and helpers for the SH7604 IBUS initiator: access sizes, FSM states, lane decode.
package sh7604_ibus_master_pkg;

  typedef enum logic [1:0] {BYTE = 2'b00, WORD = 2'b01, LONG = 2'b10} IBUS_SZ_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} IBUSM_STATE_t;

  // The reserved size code 11 behaves exactly like a long access.
  function automatic IBUS_SZ_t IBUS_SZ(input logic [1:0] raw);
    case (raw)
      2'b00:   return BYTE;
      2'b01:   return WORD;
      default: return LONG;
    endcase
  endfunction

  // Big-endian lane mask: BA[3] carries bits 31:24, i.e. byte offset 0.
  function automatic logic [3:0] IBUS_LANES(input IBUS_SZ_t sz, input logic [1:0] a);
    case (sz)
      BYTE:    IBUS_LANES = 4'b1000 >> a;
      WORD:    IBUS_LANES = a[1] ? 4'b0011 : 4'b1100;
      default: IBUS_LANES = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sh7604_ibus_master_if.sv
// CPU-side and IBUS-side signal bundle; master is the initiator's view, slave the far side.
interface sh7604_ibus_master_if;
  logic [31:0] CPU_A, CPU_DI, CPU_DO;
  logic [1:0]  CPU_SZ;
  logic        CPU_WE, CPU_SIGN, CPU_REQ, CPU_ACK, CPU_ERR;
  logic [31:0] IBUS_A, IBUS_DO, IBUS_DI;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE, IBUS_REQ, IBUS_BUSY, IBUS_ACT;

  modport master (
    input  CPU_A, CPU_DI, CPU_SZ, CPU_WE, CPU_SIGN, CPU_REQ, IBUS_DI, IBUS_BUSY, IBUS_ACT,
    output CPU_DO, CPU_ACK, CPU_ERR, IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ
  );
  modport slave (
    output CPU_A, CPU_DI, CPU_SZ, CPU_WE, CPU_SIGN, CPU_REQ, IBUS_DI, IBUS_BUSY, IBUS_ACT,
    input  CPU_DO, CPU_ACK, CPU_ERR, IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ
  );
endinterface

// File: rtl/sh7604_ibus_lane.sv
// Combinational lane steering: byte-lane mask, replicated store data, right-justified extended load data.
module sh7604_ibus_lane
  import sh7604_ibus_master_pkg::*;
(
  input  IBUS_SZ_t    sz_i,
  input  logic [1:0]  a_i,
  input  logic        sign_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  ba_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  logic [7:0]  rb;
  logic [15:0] rh;

  always_comb begin
    case (a_i)
      2'd0:    rb = rdata_i[31:24];
      2'd1:    rb = rdata_i[23:16];
      2'd2:    rb = rdata_i[15:8];
      default: rb = rdata_i[7:0];
    endcase
    rh = a_i[1] ? rdata_i[15:0] : rdata_i[31:16];

    ba_o = IBUS_LANES(sz_i, a_i);
    case (sz_i)
      BYTE: begin
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_i & rb[7]}}, rb};
      end
      WORD: begin
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sign_i & rh[15]}}, rh};
      end
      default: begin
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end
endmodule

// File: rtl/sh7604_ibus_master.sv
// SH7604 IBUS initiator: one CPU load/store per request, held on IBUS until the responder releases BUSY.
// Optional abort of stuck accesses under `define SH7604_IBUS_TIMEOUT_EN.
module sh7604_ibus_master
  import sh7604_ibus_master_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CE_R,
  input  logic CE_F,
  sh7604_ibus_master_if.master bus
);
  IBUSM_STATE_t state_q, state_d;
  IBUS_SZ_t     sz_q, sz_d, sz_in;
  logic [31:0]  a_q, a_d, di_q, di_d, do_q, do_d;
  logic         we_q, we_d, sign_q, sign_d, err_q, err_d;
  logic         misalign, on_bus, tmo_hit;
  logic [31:0]  rd_ext, wd_rep;
  logic [3:0]   ba;
  logic         unused_ce_f;

  // The falling phase belongs to the responder's read latch; nothing here is clocked by it.
  assign unused_ce_f = CE_F;

  assign sz_in    = IBUS_SZ(bus.CPU_SZ);
  assign misalign = (sz_in == WORD && bus.CPU_A[0]) ||
                    (sz_in == LONG && bus.CPU_A[1:0] != 2'b00);

  sh7604_ibus_lane u_lane (
    .sz_i    (sz_q),
    .a_i     (a_q[1:0]),
    .sign_i  (sign_q),
    .rdata_i (bus.IBUS_DI),
    .wdata_i (di_q),
    .ba_o    (ba),
    .wdata_o (wd_rep),
    .rdata_o (rd_ext)
  );

`ifdef SH7604_IBUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tmo_hit = state_q == WAIT && bus.IBUS_ACT && bus.IBUS_BUSY &&
                   cnt_q == CNT_W'(TIMEOUT);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE)
      cnt_d = '0;
    else if (state_q == WAIT && bus.IBUS_ACT && bus.IBUS_BUSY)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N)    cnt_q <= '0;
    else if (CE_R) cnt_q <= cnt_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N)    state_q <= IDLE;
    else if (CE_R) state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.CPU_REQ) state_d = misalign ? DONE : ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (!bus.IBUS_ACT || !bus.IBUS_BUSY || tmo_hit) state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    di_d   = di_q;
    sz_d   = sz_q;
    we_d   = we_q;
    sign_d = sign_q;
    err_d  = err_q;
    do_d   = do_q;
    case (state_q)
      IDLE: if (bus.CPU_REQ) begin
        a_d    = bus.CPU_A;
        di_d   = bus.CPU_DI;
        sz_d   = sz_in;
        we_d   = bus.CPU_WE;
        sign_d = bus.CPU_SIGN;
        err_d  = misalign;
      end
      // An undecoded address completes like a zero-returning read rather than stalling.
      WAIT: begin
        if (tmo_hit)
          err_d = 1'b1;
        else if (!bus.IBUS_ACT) begin
          if (!we_q) do_d = '0;
        end else if (!bus.IBUS_BUSY && !we_q)
          do_d = rd_ext;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      a_q    <= '0;
      di_q   <= '0;
      sz_q   <= BYTE;
      we_q   <= 1'b0;
      sign_q <= 1'b0;
      err_q  <= 1'b0;
      do_q   <= '0;
    end else if (CE_R) begin
      a_q    <= a_d;
      di_q   <= di_d;
      sz_q   <= sz_d;
      we_q   <= we_d;
      sign_q <= sign_d;
      err_q  <= err_d;
      do_q   <= do_d;
    end

  assign on_bus = state_q == ISSUE || state_q == WAIT;

  always_comb begin
    bus.IBUS_REQ = on_bus;
    bus.IBUS_WE  = on_bus & we_q;
    bus.IBUS_BA  = on_bus ? ba : 4'b0000;
    bus.IBUS_A   = a_q;
    bus.IBUS_DO  = wd_rep;
    bus.CPU_DO   = do_q;
    bus.CPU_ACK  = state_q == DONE;
    bus.CPU_ERR  = state_q == DONE && err_q;
  end
endmodule

// File: tb/tb_sh7604_ibus_master.sv
// Directed and randomized accesses against an arithmetic model of lane steering, latency and error rules.
module tb_sh7604_ibus_master;
`ifdef SH7604_IBUS_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 1 << 30;
`endif

  typedef struct {
    logic [31:0] a, di, rdata;
    logic [1:0]  sz;
    logic        we, sign, act;
    int          busy;
  } acc_t;

  logic CLK = 1'b0, RST_N = 1'b0, CE_R = 1'b1, CE_F = 1'b1;
  int   compared = 0, mismatched = 0;
  logic [31:0] exp_do = 32'h0;

  sh7604_ibus_master_if bus ();

`ifdef SH7604_IBUS_TIMEOUT_EN
  sh7604_ibus_master #(.TIMEOUT(TMO)) dut (.CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .bus(bus));
`else
  sh7604_ibus_master dut (.CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .bus(bus));
`endif

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // Pick the addressed bytes out of a big-endian word, then extend arithmetically.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input int nb, input logic sign,
                                           input logic [31:0] rd);
    longint v, m;
    int off;
    if (nb == 4) return rd;
    off = int'(a[1:0]);
    m   = (64'sd1 << (8 * nb)) - 1;
    v   = (longint'({32'h0, rd}) >> (8 * (4 - off - nb))) & m;
    if (sign && v > m / 2) v = v - (m + 1);
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_ba(input logic [31:0] a, input int nb);
    int off;
    off = int'(a[1:0]);
    return 4'(((1 << nb) - 1) << (4 - off - nb));
  endfunction

  function automatic logic [31:0] ref_wd(input logic [31:0] di, input int nb);
    longint v, m;
    v = 0;
    m = (64'sd1 << (8 * nb)) - 1;
    for (int i = 0; i < 4 / nb; i++) v = v | ((longint'({32'h0, di}) & m) << (8 * nb * i));
    return v[31:0];
  endfunction

  task automatic run(input acc_t t, input bit gate);
    int nb, n, k, lat;
    bit mis, tmo, acked, ce;
    nb  = nbytes(t.sz);
    mis = (int'(t.a[1:0]) % nb) != 0;
    tmo = !mis && t.act && t.busy > TMO;
    lat = mis ? 1 : tmo ? TMO + 3 : t.act ? 3 + t.busy : 3;
    if (!mis && !tmo && !t.we) exp_do = t.act ? ref_load(t.a, nb, t.sign, t.rdata) : 32'h0;

    @(negedge CLK);
    bus.CPU_A = t.a; bus.CPU_DI = t.di; bus.CPU_SZ = t.sz; bus.CPU_WE = t.we;
    bus.CPU_SIGN = t.sign; bus.CPU_REQ = 1'b1;
    bus.IBUS_ACT = t.act; bus.IBUS_DI = t.rdata; bus.IBUS_BUSY = t.busy > 0;
    n = 0; k = 0; acked = 0;
    while (!acked && k < 400) begin
      if (k > 0) @(negedge CLK);
      CE_R = gate ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge CLK);
      k++;
      ce = CE_R;
      if (ce) n++;
      #1;
      if (ce && n == 1) bus.CPU_REQ = 1'b0;
      if (ce && n == 2 + t.busy) bus.IBUS_BUSY = 1'b0;
      if (bus.CPU_ACK) acked = 1;
      else if (n >= 1 && !mis) begin
        chk("req_held", bus.IBUS_REQ, 1);
        chk("addr", bus.IBUS_A, t.a);
        chk("lanes", bus.IBUS_BA, ref_ba(t.a, nb));
        chk("we", bus.IBUS_WE, t.we);
        if (t.we) chk("wdata", bus.IBUS_DO, ref_wd(t.di, nb));
      end else if (n == 0) chk("req_idle", bus.IBUS_REQ, 0);
    end
    chk("latency", n, lat);
    chk("err", bus.CPU_ERR, mis || tmo);
    chk("cpu_do", bus.CPU_DO, exp_do);
    chk("req_drop", bus.IBUS_REQ, 0);
    chk("ba_drop", bus.IBUS_BA, 0);
    bus.IBUS_BUSY = 1'b0;
    k = 0;
    do begin
      @(negedge CLK);
      CE_R = gate ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge CLK);
      #1;
      k++;
    end while (!CE_R && k < 20);
    chk("ack_pulse", bus.CPU_ACK, 0);
  endtask

  initial begin
    acc_t t;
    bus.CPU_A = 0; bus.CPU_DI = 0; bus.CPU_SZ = 0; bus.CPU_WE = 0; bus.CPU_SIGN = 0;
    bus.CPU_REQ = 0; bus.IBUS_DI = 0; bus.IBUS_BUSY = 0; bus.IBUS_ACT = 1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_do", bus.CPU_DO, 0);
    chk("rst_ack", bus.CPU_ACK, 0);
    chk("rst_err", bus.CPU_ERR, 0);
    chk("rst_a", bus.IBUS_A, 0);
    chk("rst_wd", bus.IBUS_DO, 0);
    chk("rst_ba", bus.IBUS_BA, 0);
    chk("rst_req", {bus.IBUS_REQ, bus.IBUS_WE}, 0);
    @(negedge CLK) RST_N = 1'b1;

    t = '{a: 32'hFFFFFF04, di: 32'h64, rdata: 0, sz: 2'd2, we: 1, sign: 0, act: 1, busy: 0};
    run(t, 0);
    t = '{a: 32'hFFFFFE11, di: 0, rdata: 32'h00AB0000, sz: 2'd0, we: 0, sign: 1, act: 1, busy: 0};
    run(t, 0);
    chk("t2_signed", bus.CPU_DO, 32'hFFFFFFAB);
    t.sign = 0;
    run(t, 0);
    chk("t2_zero", bus.CPU_DO, 32'h000000AB);
    t = '{a: 32'hFFFFFF02, di: 0, rdata: 32'h1234_8765, sz: 2'd1, we: 0, sign: 0, act: 1, busy: 39};
    run(t, 0);
    t = '{a: 32'hFFFFFF01, di: 32'hBEEF, rdata: 0, sz: 2'd1, we: 1, sign: 0, act: 1, busy: 0};
    run(t, 0);
    t = '{a: 32'hFFFFFF06, di: 0, rdata: 32'hCAFE_F00D, sz: 2'd2, we: 0, sign: 1, act: 1, busy: 0};
    run(t, 0);
    t = '{a: 32'h00001000, di: 0, rdata: 32'hDEAD_BEEF, sz: 2'd2, we: 0, sign: 0, act: 0, busy: 0};
    run(t, 0);
    chk("t5_noact", bus.CPU_DO, 0);
    t = '{a: 32'hFFFFFE10, di: 0, rdata: 32'h5555_AAAA, sz: 2'd3, we: 0, sign: 0, act: 1, busy: 60};
    run(t, 0);

    for (int i = 0; i < 40; i++) begin
      t.sz    = 2'($urandom_range(0, 3));
      t.a     = $urandom;
      if ($urandom_range(0, 3) != 0) t.a = t.a & ~(32'(nbytes(t.sz)) - 32'd1);
      t.di    = $urandom;
      t.rdata = $urandom;
      t.we    = 1'($urandom_range(0, 1));
      t.sign  = 1'($urandom_range(0, 1));
      t.act   = $urandom_range(0, 9) != 0;
      t.busy  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 3);
      run(t, 1);
    end

    // Asynchronous reset in the middle of a stalled load.
    @(negedge CLK);
    CE_R = 1'b1;
    bus.CPU_A = 32'hFFFFFF10; bus.CPU_SZ = 2'd2; bus.CPU_WE = 0; bus.CPU_REQ = 1;
    bus.IBUS_ACT = 1; bus.IBUS_BUSY = 1;
    @(posedge CLK) #1 bus.CPU_REQ = 0;
    repeat (3) @(posedge CLK);
    #2;
    chk("pre_rst_req", bus.IBUS_REQ, 1);
    RST_N = 1'b0;
    #1;
    chk("arst_req", bus.IBUS_REQ, 0);
    chk("arst_ba", bus.IBUS_BA, 0);
    chk("arst_ack", bus.CPU_ACK, 0);
    repeat (3) begin
      @(posedge CLK) #1;
      chk("arst_noack", bus.CPU_ACK, 0);
    end
    @(negedge CLK);
    RST_N = 1'b1; bus.IBUS_BUSY = 0;
    exp_do = 32'h0;
    chk("arst_do", bus.CPU_DO, exp_do);
    t = '{a: 32'h0000_2003, di: 0, rdata: 32'h0102_0380, sz: 2'd0, we: 0, sign: 1, act: 1, busy: 2};
    run(t, 0);
    chk("post_rst_load", bus.CPU_DO, 32'hFFFFFF80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sh7604_ibus_master.md
Name: sh7604_ibus_master

Overview:
- CPU-side initiator for the SH7604 internal peripheral bus (IBUS).
- Accepts a single byte, word or long load/store from the CPU core and drives the IBUS request signals: address, write data, byte lanes, write-enable and REQ.
- Holds the request while the selected peripheral (DIVU, FRT, WDT, ...) asserts IBUS_BUSY, then returns lane-aligned, extended read data to the CPU with a one-cycle acknowledge.

Parameters:
- TIMEOUT, 255, number of CE_R edges in WAIT before the access is aborted (used only when SH7604_IBUS_TIMEOUT_EN is defined).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- CE_R  in  1  rising-phase clock enable; all state updates occur on it.
- CE_F  in  1  falling-phase enable; no internal state uses it; documents the responder read-latch phase.
- CPU_A  in  32  byte address.
- CPU_DI  in  32  store data, right-justified.
- CPU_SZ  in  2  access size: 00 byte, 01 word, 10 long, 11 reserved (treated as long).
- CPU_WE  in  1  1 = store.
- CPU_SIGN  in  1  1 = sign-extend loads, 0 = zero-extend.
- CPU_REQ  in  1  request strobe, level-sampled in IDLE.
- CPU_DO  out  32  load result, held until the next ACK.
- CPU_ACK  out  1  one-CE_R-cycle completion pulse.
- CPU_ERR  out  1  one-cycle address-error or timeout pulse (coincides with ACK).
- IBUS_A  out  32  bus address.
- IBUS_DO  out  32  bus write data.
- IBUS_DI  in  32  bus read data.
- IBUS_BA  out  4  byte lanes; bit3 = bits 31:24.
- IBUS_WE  out  1  write strobe.
- IBUS_REQ  out  1  request.
- IBUS_BUSY  in  1  responder stall, registered by the responder.
- IBUS_ACT  in  1  a responder decodes IBUS_A.

Behaviour:
- Reset values:
  - all outputs 0; state IDLE.
  - The async reset aborts any access mid-flight: REQ drops immediately and no ACK is issued.
- States: IDLE, ISSUE, WAIT, DONE. All transitions occur on CLK edges with CE_R=1.
- IDLE:
  - If CPU_REQ=1, latch A, DI, SZ, WE and SIGN.
  - Misaligned address → DONE with ERR=1; no bus cycle, REQ stays 0.
    - word: A[0]=1.
    - long: A[1:0]≠0.
  - Otherwise go to ISSUE, driving IBUS_A=A and IBUS_REQ=1.
- ISSUE (1 edge):
  - Exists because the responder registers BUSY one CE_R after REQ; BUSY is not sampled here.
  - Go to WAIT.
- WAIT: evaluate on each CE_R.
  - IBUS_ACT=0 → complete, read data 0.
  - IBUS_BUSY=0 → complete: capture lane-extracted IBUS_DI into CPU_DO (loads only), drop REQ/WE/BA, go to DONE.
  - IBUS_BUSY=1 → stay in WAIT, holding all IBUS outputs stable.
- DONE:
  - CPU_ACK=1 for exactly 1 CE_R cycle, then IDLE.
  - CPU_REQ is ignored in DONE.
  - Minimum throughput is 1 access per 4 CE_R edges.
- Minimum latency is REQ-to-ACK 3 CE_R edges; each BUSY-high WAIT edge adds 1.
- Byte lanes and write data (big-endian), by A[1:0]:
  - byte: BA = 1000/0100/0010/0001; IBUS_DO = DI[7:0] replicated ×4.
  - word: BA = 1100 (A[1]=0) or 0011 (A[1]=1); IBUS_DO = DI[15:0] replicated ×2.
  - long: BA = 1111; IBUS_DO = DI.
- IBUS_WE=1 only in ISSUE/WAIT of a store. IBUS_BA is driven for loads too.
- Read extraction:
  - Select the addressed lane(s), right-justify.
  - Extend to 32 bits per SIGN. A long load is passed unchanged.
- Stores leave CPU_DO unchanged.
- CE_R=0 freezes all state; outputs stay held.

Optional Feature:
- Macro SH7604_IBUS_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter clears in ISSUE and increments on each WAIT edge with BUSY=1.
  - When it reaches TIMEOUT: drop REQ, go to DONE with ACK=1, ERR=1, CPU_DO unchanged.
- Undefined:
  - No counter; WAIT holds indefinitely while BUSY=1.
  - The ERR timeout source is absent.

Decomposition:
- Shared package SH7604_PKG gains:
  - IBUS_SZ_t enum (BYTE, WORD, LONG).
  - IBUSM_STATE_t enum (IDLE, ISSUE, WAIT, DONE).
  - function IBUS_LANES(sz, a[1:0]) returning BA.
- Sub-module sh7604_ibus_lane (combinational): takes SZ, A[1:0], SIGN, raw read data and store data; produces BA, the replicated write data and the extended read data. The top level keeps the FSM, latches and timeout.

Test Plan:
1. Long store A=FFFFFF04, DI=00000064, BUSY never asserted → BA=1111, WE=1, REQ held for exactly 2 CE_R edges; ACK on the 3rd edge; ERR=0.
2. Byte load A=FFFFFE11, IBUS_DI=00AB0000, SIGN=1 → BA=0100; CPU_DO=FFFFFFAB. Repeat with SIGN=0 → 000000AB.
3. Word load A=FFFFFF02, responder holds BUSY for 39 edges → IBUS_A/BA/REQ stable throughout; ACK 42 edges after CPU_REQ; CPU_DO = low half of IBUS_DI after BUSY falls.
4. Word store at A=FFFFFF01, then long load at A=FFFFFF06 → ERR+ACK on the 1st edge each; IBUS_REQ never asserted; CPU_DO unchanged.
5. IBUS_ACT=0 for a load at 00001000 → ACK after 3 edges; CPU_DO=00000000.
6. With SH7604_IBUS_TIMEOUT_EN, TIMEOUT=4, BUSY stuck at 1 → ACK+ERR 7 edges after request; REQ low. Then assert RST_N=0 mid-WAIT on a second access → REQ drops asynchronously; no ACK.
